// File: rtl/micro_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : micro_pkg
// Brief    : Shared control-word bit indices, sequencer states and fault codes.
// Revision : 1.0
// ============================================================================
package micro_pkg;

    localparam int unsigned c_cw_width           = 21;
    localparam int unsigned c_wmfc_bit           = 8;
    localparam int unsigned c_select_decoder_bit = 16;
    localparam int unsigned c_endd_bit           = c_cw_width - 1;
    localparam int unsigned c_slots              = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        FAULT    = 2'd3
    } state_e;

    localparam logic [1:0] c_fault_none     = 2'b00;
    localparam logic [1:0] c_fault_illegal  = 2'b01;
    localparam logic [1:0] c_fault_timeout  = 2'b10;
    localparam logic [1:0] c_fault_overflow = 2'b11;

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts memory-wait cycles; expired is high at TIMEOUT-1.
// Revision : 1.0
// ============================================================================
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned         c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Saturates at the last count so expired stays asserted until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Brief    : Microprogram sequencer owning the control address register.
// Revision : 1.0
// ============================================================================
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int unsigned          N          = 7,
    parameter int unsigned          SZ         = c_cw_width,
    parameter int unsigned          OPW        = 4,
    parameter int unsigned          SLOTS      = c_slots,
    parameter logic [(1<<OPW)-1:0]  LEGAL_MASK = 16'hFEFE,
    parameter int unsigned          TIMEOUT    = 16,
    parameter int unsigned          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SZ-1:0]    cbr,
    input  logic [OPW-1:0]   opcode,
    input  logic             mfc,
    input  logic             run,
    input  logic             fault_clr,
    output logic [N-1:0]     car,
    output logic             cw_valid,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned c_slot_bits = $clog2(SLOTS);
    // ENDD tracks the top bit of whatever control-word width is configured.
    localparam int unsigned c_endd      = SZ - 1;

    state_e           state_q;
    state_e           state_d;
    logic [N-1:0]     car_q;
    logic [N-1:0]     car_d;
    logic [1:0]       fault_code_q;
    logic [1:0]       fault_code_d;
    logic [CNT_W-1:0] instr_count_q;
    logic [CNT_W-1:0] instr_count_d;

    logic             w_wmfc;
    logic             w_sel;
    logic             w_endd;
    logic             w_legal;
    logic [N-1:0]     w_dispatch;
    logic             w_advance;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_timer_expired;
    logic             w_unused_cbr;

    assign w_wmfc       = cbr[c_wmfc_bit];
    assign w_sel        = cbr[c_select_decoder_bit];
    assign w_endd       = cbr[c_endd];
    assign w_legal      = LEGAL_MASK[opcode];
    assign w_dispatch   = N'(opcode) << c_slot_bits;
    assign w_unused_cbr = ^cbr;
    assign w_timer_en   = (state_q == WAIT_MEM);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_expired (w_timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        car_d         = car_q;
        fault_code_d  = fault_code_q;
        instr_count_d = instr_count_q;
        w_timer_clr   = 1'b0;
        w_advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_wmfc && !mfc) begin
                    state_d     = WAIT_MEM;
                    w_timer_clr = 1'b1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            WAIT_MEM: begin
                // A completing access on the timeout edge still counts as success.
                if (mfc) begin
                    w_advance = 1'b1;
                end else if (w_timer_expired) begin
                    state_d      = FAULT;
                    fault_code_d = c_fault_timeout;
                    car_d        = '0;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d      = IDLE;
                    fault_code_d = c_fault_none;
                end
            end
            default: begin
                state_d = IDLE;
                car_d   = '0;
            end
        endcase

        if (w_advance) begin
            if (w_endd) begin
                car_d         = '0;
                instr_count_d = instr_count_q + 1'b1;
                state_d       = run ? RUN : IDLE;
            end else if (w_sel) begin
                if (w_legal) begin
                    car_d   = w_dispatch;
                    state_d = RUN;
                end else begin
                    car_d        = '0;
                    fault_code_d = c_fault_illegal;
                    state_d      = FAULT;
                end
            end else if (&car_q) begin
                car_d        = '0;
                fault_code_d = c_fault_overflow;
                state_d      = FAULT;
            end else begin
                car_d   = car_q + 1'b1;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            car_q         <= '0;
            fault_code_q  <= c_fault_none;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            car_q         <= car_d;
            fault_code_q  <= fault_code_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign car         = car_q;
    assign cw_valid    = (state_q == RUN) || (state_q == WAIT_MEM);
    assign busy        = (state_q != IDLE);
    assign fault       = (state_q == FAULT);
    assign fault_code  = fault_code_q;
    assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer that owns the control address register (CAR) feeding the control store. Each cycle it reads back the control word the store returns for the current CAR and the opcode field of IR, then picks the next CAR: increment, dispatch to the opcode's routine, return to fetch, or hold while memory is busy. It also gates control-word validity, stops cleanly between instructions, and latches fault conditions for the debug/status path.

## Interface
Parameters:
- N, 7: CAR width.
- SZ, 21: control word width.
- OPW, 4: opcode width.
- SLOTS, 4: microwords per routine; must be a power of two.
- LEGAL_MASK, 16'hFEFE: bit k set means opcode k has a routine.
  - Opcode 0 (fetch) and opcode 8 are illegal.
- TIMEOUT, 16: maximum WAIT_MEM cycles before a memory fault.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cbr  in  SZ  control word for the current CAR (combinational from the control store).
- opcode  in  OPW  opcode field of IR.
- mfc  in  1  memory function complete (level).
- run  in  1  1 = execute; 0 = stop at the next instruction boundary.
- fault_clr  in  1  clears FAULT; returns to IDLE.
- car  out  N  control address register.
- cw_valid  out  1  datapath may act on cbr this cycle.
- busy  out  1  state is not IDLE.
- fault  out  1  state is FAULT.
- fault_code  out  2  01 illegal opcode, 10 memory timeout, 11 CAR overflow, 00 none.
- instr_count  out  CNT_W  instructions retired; wraps at 2^CNT_W.

## Operation
Reset value of every output is 0; the state machine resets to IDLE.

Control bits used from cbr: WMFC = 8, SELECT_DECODER = 16, ENDD = SZ-1.

States:
- IDLE
  - car = 0, cw_valid = 0.
  - Goes to RUN when run = 1.
- RUN
  - cw_valid = 1.
  - Next-CAR priority, evaluated each edge:
    1. WMFC set and mfc = 0: hold car, go to WAIT_MEM, clear the wait counter.
    2. ENDD set: car <= 0 and instr_count increments; stay in RUN if run = 1, otherwise go to IDLE.
    3. SELECT_DECODER set with LEGAL_MASK[opcode] = 1: car <= opcode*SLOTS.
    4. SELECT_DECODER set with LEGAL_MASK[opcode] = 0: go to FAULT with code 01, car <= 0.
    5. Otherwise, car = 2^N-1: go to FAULT with code 11. Else car <= car+1.
  - A WMFC word with mfc = 1 in the same cycle does not stall; rules 2–5 apply to it.
- WAIT_MEM
  - car held, cw_valid = 1; the datapath keeps re-applying the same word (for example rnw).
  - Wait counter increments each cycle.
  - mfc = 1: apply rules 2–5 to the held word and return to RUN.
  - Otherwise, when the counter reaches TIMEOUT-1: go to FAULT with code 10.
  - If mfc arrives on the same edge as the timeout, mfc wins.
- FAULT
  - car = 0, cw_valid = 0, fault = 1; fault_code is held.
  - fault_clr = 1: go to IDLE and clear fault_code.
  - run is ignored in FAULT.

Boundary rules:
- run deasserted mid-instruction: the instruction completes through its ENDD word, then the block goes to IDLE.
- fault_clr outside FAULT is ignored.
- instr_count is not cleared by fault_clr; only rst clears it.
- rst mid-operation: immediate return to IDLE with all outputs 0, regardless of any pending memory access.

## Timing
- car is registered. cbr is valid in the same cycle as car, so one microword executes per cycle.
- Latency from run rising in IDLE to the first fetch word being valid: 1 cycle.
- Fetch takes 4 cycles plus the mfc wait; the dispatch word is at fetch+3.
- Zero memory wait means mfc = 1 during the WMFC cycle.
- A fault is visible on the cycle after the offending edge decision.
- Dispatch target depends on opcode sampled on the SELECT_DECODER edge; IR must be stable by then.

## Structure
- Shared package micro_pkg:
  - control-bit indices (WMFC, SELECT_DECODER, ENDD);
  - state enum {IDLE, RUN, WAIT_MEM, FAULT};
  - fault code constants;
  - SLOTS.
  - The control store and the datapath use the same indices.
- One sub-module, mem_wait_timer: clear/enable inputs and an expired output at TIMEOUT-1.

## Test plan
- Reset, then run = 1, opcode = 3, mfc = 1 immediately → car sequence 0,1,2,3,12,0; instr_count = 1.
- Fetch with mfc delayed 5 cycles → car holds 1 for 6 cycles with cw_valid = 1, then goes to 2.
- mfc never asserted → FAULT after 16 cycles in WAIT_MEM, fault_code = 10; fault_clr → IDLE.
- opcode = 8 at dispatch → FAULT, fault_code = 01, car = 0; opcode = 0 gives the same result.
- run dropped during the opcode 1 routine → completes car 4,5,6, then IDLE with car = 0 and busy = 0.
- rst pulsed while in WAIT_MEM → all outputs 0 asynchronously; instr_count = 0.
